netapp_pkt_gen: RTL
===================

# netapp_pkt_gen

Parametrised AXI-Stream test-frame generator for the netapp datapath.
- Emits Ethernet/IPv4/UDP frames built from a 42-byte header template, a 32-bit sequence number and an incrementing payload pattern.
- Frame length, inter-frame gap and frame count are configurable at run time.
- Fully honours `m_axis_tready` back-pressure.
- Sits in place of the fixed two-beat frame source, feeding the output arbiter / MAC TX path.

## Interface
- `C_M_AXIS_DATA_WIDTH`, 256: tdata width in bits; must be a multiple of 64.
- `C_M_AXIS_TUSER_WIDTH`, 128: tuser width in bits.
- `MAX_FRAME_BYTES`, 1514: upper clamp on frame length, FCS excluded.
- `axis_aclk` in 1: the single clock.
- `axis_resetn` in 1: asynchronous, active-low reset.
- `cfg_hdr` in 336: header template; byte k = `cfg_hdr[8k+7:8k]`; byte 0 is the first byte on the wire.
- `cfg_payload_len` in 16: UDP payload bytes, sequence field included.
- `cfg_gap_cycles` in 16: idle cycles between frames.
- `cfg_frame_count` in 32: number of frames to send; 0 means unlimited.
- `cfg_src_port` in 8: copied to tuser.
- `cfg_dst_port` in 8: copied to tuser.
- `start` in 1: single-cycle pulse that launches a run.
- `stop` in 1: single-cycle pulse that ends the run at the next frame boundary.
- `m_axis_tdata` out DW: frame data.
- `m_axis_tkeep` out DW/8: byte enables.
- `m_axis_tuser` out TW: NetFPGA metadata.
- `m_axis_tvalid` out 1: beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tlast` out 1: last beat of frame.
- `busy` out 1: high while not IDLE.
- `done` out 1: one-cycle pulse when a run ends.
- `frames_sent` out 32: frames completed in the current run.

## Operation
- States:
  - IDLE: waiting for `start`.
  - SEND: emitting frame beats.
  - GAP: counting idle cycles.
- `start` in IDLE:
  - Latches all `cfg_*`.
  - Clears sequence number and `frames_sent`.
  - Enters SEND.
  - `start` outside IDLE is ignored.
- Payload length: P = clamp(`cfg_payload_len`, 18, MAX_FRAME_BYTES−42).
- Frame length: L = 42 + P (range 60..MAX_FRAME_BYTES).
- Beats per frame: ceil(L/(DW/8)).
- Byte k of a frame:
  - k < 42: header byte k.
  - k = 42..45: sequence number, big-endian (byte 42 = seq[31:24]).
  - k ≥ 46: (k−46) mod 256.
  - k ≥ L: 0x00.
- tkeep:
  - All ones on every beat except the last.
  - Last beat: the low (L mod (DW/8)) bits are set; all ones if the remainder is 0.
- tuser:
  - [15:0] = L, [23:16] = src port, [31:24] = dst port; all other bits 0.
  - Constant for all beats of a frame.
- The header is not patched; IP/UDP length and checksum fields are software's responsibility.
- Sequence number: increments by 1 after each tlast handshake and wraps at 2^32.
- On tlast handshake:
  - `frames_sent` increments.
  - If `frames_sent` reaches a nonzero `cfg_frame_count`, or `stop` is pending: go to IDLE and pulse `done`.
  - Else if gap > 0: go to GAP.
  - Else: stay in SEND and start the next frame.
- `stop` during SEND:
  - Stays pending.
  - The current frame always completes; it is never truncated.
- `stop` during GAP: immediate IDLE plus `done`.
- `stop` in IDLE: ignored.

## Timing
- Reset values:
  - `m_axis_tvalid`, `m_axis_tlast`, `busy`, `done` = 0.
  - `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tuser` = 0.
  - `frames_sent` = 0.
  - State = IDLE.
- Reset asserted mid-frame: `m_axis_tvalid` drops asynchronously; no partial completion.
- Outputs are registered. `start` sampled in cycle N gives the first beat valid in cycle N+1.
- AXI-Stream rules:
  - Once `m_axis_tvalid` is high, it and tdata/tkeep/tuser/tlast stay stable until `m_axis_tready`.
  - The beat advances only on tvalid && tready.
  - `m_axis_tvalid` never depends combinationally on `m_axis_tready`.
- Gap = 0: the next frame's first beat is presented in the cycle after the tlast handshake, with tvalid continuously high.
- Gap = G > 0: tvalid is low for exactly G cycles after the tlast handshake cycle.
- `done` is high in the cycle after the final tlast handshake; `busy` falls in that same cycle.
- Throughput: one beat per cycle when tready is held high.

## Structure
- Package `netapp_pkg` holds:
  - HDR_BYTES = 42, SEQ_BYTES = 4, MIN_PAYLOAD = 18.
  - State encoding.
  - tuser field offsets.
- Sub-module `netapp_beat_builder`: combinational. Inputs are beat index, L, header, sequence number and the latched parameters; outputs are the tdata/tkeep/tlast values for that beat. Its outputs are registered in the top FSM.

## Test plan
- P = 18, count = 1, tready = 1:
  - Exactly 2 beats with L = 60, tuser[15:0] = 60.
  - Last tkeep = 0x0FFFFFFF.
  - Bytes 42..45 = 00 00 00 00; byte 46 = 0x00; `done` 1 cycle after tlast.
- P = 22 gives 2 beats with last tkeep = 0xFFFFFFFF. P = 100 (L = 142) gives 5 beats with last tkeep = 0x00003FFF.
- count = 3, gap = 3:
  - Sequence fields read 0, 1, 2.
  - Exactly 3 tvalid-low cycles between frames.
  - `frames_sent` = 3; exactly one `done` pulse.
- Random tready at 30% duty, P = 200, count = 4:
  - No beat lost or duplicated.
  - Outputs stable while stalled; byte stream matches the model.
- count = 0, gap = 0, `stop` mid-frame 5:
  - Frames back-to-back with tvalid continuously high.
  - Frame 5 completes, then IDLE; `frames_sent` = 5.
- `axis_resetn` pulsed low mid-frame: tvalid = 0 immediately and `busy` = 0. A new `start` restarts with sequence number 0.

Source files
------------

// File: rtl/netapp_pkg.sv
// Shared constants, state encoding and helpers for the netapp test-frame generator.
package netapp_pkg;

  localparam int unsigned HDR_BYTES     = 42;
  localparam int unsigned SEQ_BYTES     = 4;
  localparam int unsigned MIN_PAYLOAD   = 18;
  localparam int unsigned PAYLOAD_OFS   = HDR_BYTES + SEQ_BYTES;
  localparam int unsigned HDR_W         = HDR_BYTES * 8;
  localparam int unsigned LEN_W         = 16;
  localparam int unsigned SEQ_W         = 32;
  localparam int unsigned CNT_W         = 32;
  localparam int unsigned PORT_W        = 8;
  localparam int unsigned IDX_W         = 16;

  localparam int unsigned TUSER_LEN_LSB = 0;
  localparam int unsigned TUSER_SRC_LSB = 16;
  localparam int unsigned TUSER_DST_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Wire length (FCS excluded) after clamping the requested payload.
  function automatic logic [LEN_W-1:0] frame_len(input logic [LEN_W-1:0] payload_len,
                                                 input int unsigned max_frame);
    int unsigned p;
    p = 32'(payload_len);
    if (p < MIN_PAYLOAD) p = MIN_PAYLOAD;
    if (p > max_frame - HDR_BYTES) p = max_frame - HDR_BYTES;
    return LEN_W'(p + HDR_BYTES);
  endfunction

endpackage

// File: rtl/netapp_pkt_gen_if.sv
// AXI-Stream master bus carrying generated frames.
interface netapp_pkt_gen_if #(
  parameter int unsigned DW = 256,
  parameter int unsigned TW = 128
);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic [TW-1:0]   tuser;
  logic            tvalid;
  logic            tready;
  logic            tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/netapp_beat_builder.sv
// Combinational builder of one frame beat: header, big-endian sequence, byte-count payload.
module netapp_beat_builder
  import netapp_pkg::*;
#(
  parameter int unsigned DW = 256
) (
  input  logic [IDX_W-1:0] beat_idx,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [HDR_W-1:0] hdr,
  input  logic [SEQ_W-1:0] seq,
  output logic [DW-1:0]    tdata_c,
  output logic [DW/8-1:0]  tkeep_c,
  output logic             tlast_c
);

  localparam int unsigned KW = DW / 8;

  always_comb begin
    logic [31:0] base;
    logic [31:0] k;
    logic [7:0]  b;
    tdata_c = '0;
    tkeep_c = '0;
    base    = 32'(beat_idx) * 32'(KW);
    k       = '0;
    b       = '0;
    for (int unsigned j = 0; j < KW; j++) begin
      k = base + 32'(j);
      b = 8'h00;
      if (k < 32'(frame_len)) begin
        tkeep_c[j] = 1'b1;
        if (k < 32'(HDR_BYTES)) begin
          b = hdr[{k[5:0], 3'b000} +: 8];
        end else if (k < 32'(PAYLOAD_OFS)) begin
          case (2'(k - 32'(HDR_BYTES)))
            2'd0:    b = seq[31:24];
            2'd1:    b = seq[23:16];
            2'd2:    b = seq[15:8];
            default: b = seq[7:0];
          endcase
        end else begin
          b = 8'(k - 32'(PAYLOAD_OFS));
        end
      end
      tdata_c[8*j +: 8] = b;
    end
    tlast_c = (base + 32'(KW)) >= 32'(frame_len);
  end

endmodule

// File: rtl/netapp_pkt_gen.sv
// Run-time configurable Ethernet/IPv4/UDP test-frame generator on an AXI-Stream master.
module netapp_pkt_gen
  import netapp_pkg::*;
#(
  parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned MAX_FRAME_BYTES      = 1514
) (
  input  logic              axis_aclk,
  input  logic              axis_resetn,
  input  logic [HDR_W-1:0]  cfg_hdr,
  input  logic [LEN_W-1:0]  cfg_payload_len,
  input  logic [15:0]       cfg_gap_cycles,
  input  logic [CNT_W-1:0]  cfg_frame_count,
  input  logic [PORT_W-1:0] cfg_src_port,
  input  logic [PORT_W-1:0] cfg_dst_port,
  input  logic              start,
  input  logic              stop,
  netapp_pkt_gen_if.master  m_axis,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  frames_sent
);

  localparam int unsigned DW = C_M_AXIS_DATA_WIDTH;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned TW = C_M_AXIS_TUSER_WIDTH;

  state_t            state_q, state_d;
  logic [HDR_W-1:0]  hdr_q, hdr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [15:0]       gap_q, gap_d;
  logic [15:0]       gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  frames_q, frames_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              stop_pend_q, stop_pend_d;
  logic [DW-1:0]     tdata_q, tdata_d;
  logic [KW-1:0]     tkeep_q, tkeep_d;
  logic [TW-1:0]     tuser_q, tuser_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, done_q, done_d;

  logic [LEN_W-1:0]  cfg_len_c;
  logic [TW-1:0]     cfg_tuser_c;
  logic [HDR_W-1:0]  bld_hdr_c;
  logic [LEN_W-1:0]  bld_len_c;
  logic [IDX_W-1:0]  bld_idx_c;
  logic [SEQ_W-1:0]  bld_seq_c;
  logic [DW-1:0]     bld_tdata_c;
  logic [KW-1:0]     bld_tkeep_c;
  logic              bld_tlast_c;
  logic              hs_c;
  logic              load_c;

  assign hs_c      = tvalid_q & m_axis.tready;
  assign cfg_len_c = frame_len(cfg_payload_len, MAX_FRAME_BYTES);

  always_comb begin
    cfg_tuser_c = '0;
    cfg_tuser_c[TUSER_LEN_LSB +: LEN_W]  = cfg_len_c;
    cfg_tuser_c[TUSER_SRC_LSB +: PORT_W] = cfg_src_port;
    cfg_tuser_c[TUSER_DST_LSB +: PORT_W] = cfg_dst_port;
  end

  // Builder always describes the beat to be loaded next: successor beat, or beat 0 of the next frame.
  always_comb begin
    bld_hdr_c = (state_q == ST_IDLE) ? cfg_hdr : hdr_q;
    bld_len_c = (state_q == ST_IDLE) ? cfg_len_c : len_q;
    bld_idx_c = (state_q == ST_SEND && !tlast_q) ? idx_q + IDX_W'(1) : '0;
    if (state_q == ST_IDLE)                bld_seq_c = '0;
    else if (state_q == ST_SEND && tlast_q) bld_seq_c = seq_q + SEQ_W'(1);
    else                                   bld_seq_c = seq_q;
  end

  netapp_beat_builder #(.DW(DW)) u_builder (
    .beat_idx  (bld_idx_c),
    .frame_len (bld_len_c),
    .hdr       (bld_hdr_c),
    .seq       (bld_seq_c),
    .tdata_c   (bld_tdata_c),
    .tkeep_c   (bld_tkeep_c),
    .tlast_c   (bld_tlast_c)
  );

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    len_d       = len_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    count_d     = count_q;
    frames_d    = frames_q;
    seq_d       = seq_q;
    idx_d       = idx_q;
    stop_pend_d = stop_pend_q;
    tdata_d     = tdata_q;
    tkeep_d     = tkeep_q;
    tuser_d     = tuser_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    done_d      = 1'b0;
    load_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          hdr_d       = cfg_hdr;
          len_d       = cfg_len_c;
          gap_d       = cfg_gap_cycles;
          count_d     = cfg_frame_count;
          tuser_d     = cfg_tuser_c;
          seq_d       = '0;
          frames_d    = '0;
          stop_pend_d = 1'b0;
          load_c      = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs_c) begin
          if (!tlast_q) begin
            load_c = 1'b1;
          end else begin
            frames_d = frames_q + CNT_W'(1);
            seq_d    = seq_q + SEQ_W'(1);
            if (((count_q != '0) && (frames_d == count_q)) || stop_pend_q || stop) begin
              state_d  = ST_IDLE;
              done_d   = 1'b1;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else begin
              load_c = 1'b1;
            end
          end
        end
      end
      ST_GAP: begin
        if (stop) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (gap_cnt_q == 16'd1) begin
          load_c  = 1'b1;
          state_d = ST_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load_c) begin
      tdata_d  = bld_tdata_c;
      tkeep_d  = bld_tkeep_c;
      tlast_d  = bld_tlast_c;
      tvalid_d = 1'b1;
      idx_d    = bld_idx_c;
    end
  end

  always_ff @(posedge axis_aclk or negedge axis_resetn) begin
    if (!axis_resetn) begin
      state_q     <= ST_IDLE;
      hdr_q       <= '0;
      len_q       <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      count_q     <= '0;
      frames_q    <= '0;
      seq_q       <= '0;
      idx_q       <= '0;
      stop_pend_q <= 1'b0;
      tdata_q     <= '0;
      tkeep_q     <= '0;
      tuser_q     <= '0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      len_q       <= len_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      count_q     <= count_d;
      frames_q    <= frames_d;
      seq_q       <= seq_d;
      idx_q       <= idx_d;
      stop_pend_q <= stop_pend_d;
      tdata_q     <= tdata_d;
      tkeep_q     <= tkeep_d;
      tuser_q     <= tuser_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= done_d;
    end
  end

  assign m_axis.tdata  = tdata_q;
  assign m_axis.tkeep  = tkeep_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_sent   = frames_q;

endmodule
